combo_lock_fsm: RTL and testbench
=================================

# combo_lock_fsm

Combination-checking core of the Basys combo lock. It consumes the board-level button levels (`btnc`, `btnl`, `btnu`, already debounced upstream) and the low switch nibble. It collects a four-digit entry, compares it against a programmed code, and drives unlock, error and lockout status. Its outputs feed the board top: `disp_digit` goes to the seven-segment decoder, and the status signals go to the LED array.

## Interface
- `CODE`, 16'h1234, secret code as four 4-bit digits; `[15:12]` is entered first, `[3:0]` last.
- `MAX_FAIL`, 3, consecutive mismatches that trigger lockout (1..3).
- `OPEN_CYCLES`, 100_000_000, number of cycles `unlocked` stays high.
- `LOCK_CYCLES`, 500_000_000, number of cycles lockout lasts.
- `clk` in 1: board clock; the only clock.
- `reset` in 1: synchronous, active-low reset.
- `btnc` in 1: enter the current digit (level input; a press is its rising edge).
- `btnl` in 1: clear the digits entered so far (rising edge).
- `btnu` in 1: relock early while open (rising edge).
- `swt` in 4: digit value, 0..15.
- `unlocked` out 1: high in OPEN.
- `locked_out` out 1: high in LOCKOUT.
- `err` out 1: high from a mismatch until the next accepted `btnc` or `btnl` edge.
- `digit_cnt` out 3: digits entered, 0..4.
- `disp_digit` out 4: last digit accepted.
- `fail_cnt` out 2: count of consecutive mismatches.

## Operation
- **Edge detect:** one previous-value register per button; press = `btn & ~prev`.
  - `prev` registers reset to 1, so a button held through reset does not register a press.
  - A held button yields exactly one press.
- **States:** IDLE, ENTRY, CHECK, OPEN, LOCKOUT.
- **IDLE:** on `btnc` press, shift in `swt`, set `digit_cnt` = 1, clear `err`, go to ENTRY. A `btnl` press clears `err`.
- **ENTRY:**
  - `btnc` press: shift `swt` into the 16-bit entry register (new digit enters at `[3:0]`), increment `digit_cnt`.
  - When the 4th digit is accepted, go to CHECK.
  - `btnl` press: `digit_cnt` = 0, entry = 0, `disp_digit` = 0, go to IDLE.
  - `btnl` and `btnc` presses in the same cycle: clear wins and the digit is discarded.
- **CHECK** (exactly 1 cycle; all presses ignored):
  - Entry == `CODE`: go to OPEN, `fail_cnt` = 0, timer = `OPEN_CYCLES`-1.
  - Mismatch with `fail_cnt`+1 == `MAX_FAIL`: go to LOCKOUT, timer = `LOCK_CYCLES`-1, `fail_cnt` = `MAX_FAIL`.
  - Other mismatch: `fail_cnt`+1, `err` = 1, go to IDLE.
  - On every exit, `digit_cnt` = 0 and entry = 0.
- **OPEN:**
  - Timer decrements each cycle; timer == 0 goes to IDLE.
  - `btnu` press goes to IDLE immediately and takes priority over expiry.
  - `btnc`/`btnl` presses are ignored.
- **LOCKOUT:** all buttons are ignored; timer decrements; at 0 go to IDLE with `fail_cnt` = 0 and `err` = 0.
- **Timer:** a single shared down-counter, width `$clog2(max(OPEN_CYCLES, LOCK_CYCLES))`. It does not wrap, because its state always exits at 0.
- **Reset (low at a clock edge), from any state:**
  - State IDLE.
  - All outputs 0: `unlocked`, `locked_out`, `err`, `digit_cnt`, `disp_digit`, `fail_cnt`.
  - Entry register and timer 0; edge-detect `prev` registers 1.
  - Reset mid-OPEN or mid-LOCKOUT aborts immediately.

## Timing
- All outputs are registered or decoded from registered state; no combinational path from the buttons to the outputs.
- A press sampled at edge n updates `digit_cnt` and `disp_digit` after edge n.
- After the 4th press at edge n: CHECK after edge n; OPEN, LOCKOUT or IDLE+`err` after edge n+1.
- `unlocked` is high for exactly `OPEN_CYCLES` cycles. `locked_out` is high for exactly `LOCK_CYCLES` cycles.
- Minimum press-to-press spacing is 2 cycles (release plus press); no FIFO, and presses during CHECK are lost.

## Test plan
Bench parameters: `OPEN_CYCLES`=8, `LOCK_CYCLES`=16, `MAX_FAIL`=3.
- **Correct code:** enter 1, 2, 3, 4 -> `unlocked`=1 exactly 2 edges after the 4th press, held 8 cycles, then 0; `fail_cnt`=0.
- **Wrong code then recovery:** enter 1, 2, 3, 5 -> `err`=1, `fail_cnt`=1, `unlocked` stays 0. Next `btnc` press -> `err`=0, `digit_cnt`=1.
- **Lockout:** three wrong codes -> `locked_out`=1 for 16 cycles. All presses during lockout are ignored (`digit_cnt` stays 0). Afterwards state is IDLE with `fail_cnt`=0.
- **Clear and collision:** enter 1, 2, then `btnl` -> `digit_cnt`=0, `disp_digit`=0. Then `btnc` and `btnl` pressed together -> `digit_cnt` stays 0.
- **Held button:** `btnc` held high for 10 cycles with `swt`=7 -> `digit_cnt`=1, `disp_digit`=7. Holding `btnc` through reset deassertion -> no digit accepted.
- **Early relock and reset:** in OPEN, a `btnu` press at cycle 3 -> `unlocked`=0 the next cycle. Separately, `reset`=0 in mid-LOCKOUT -> `locked_out`=0 and all outputs 0 after that edge.

Source files
------------

// File: rtl/combo_lock_fsm_if.sv
// rtl/combo_lock_fsm_if.sv - button/switch inputs and status outputs of the combo lock core
interface combo_lock_fsm_if;
    logic       btnc;
    logic       btnl;
    logic       btnu;
    logic [3:0] swt;
    logic       unlocked;
    logic       locked_out;
    logic       err;
    logic [2:0] digit_cnt;
    logic [3:0] disp_digit;
    logic [1:0] fail_cnt;

    modport master (
        output btnc, btnl, btnu, swt,
        input  unlocked, locked_out, err, digit_cnt, disp_digit, fail_cnt
    );

    modport slave (
        input  btnc, btnl, btnu, swt,
        output unlocked, locked_out, err, digit_cnt, disp_digit, fail_cnt
    );
endinterface

// File: rtl/combo_lock_fsm.sv
// rtl/combo_lock_fsm.sv - four-digit combination checker with open timer and failure lockout
module combo_lock_fsm #(
    parameter logic [15:0] CODE        = 16'h1234,
    parameter int          MAX_FAIL    = 3,
    parameter int          OPEN_CYCLES = 100_000_000,
    parameter int          LOCK_CYCLES = 500_000_000
) (
    input  logic             clk,
    input  logic             reset,
    combo_lock_fsm_if.slave  bus
);
    localparam int MAX_CYC = (OPEN_CYCLES > LOCK_CYCLES) ? OPEN_CYCLES : LOCK_CYCLES;
    localparam int TW      = (MAX_CYC > 1) ? $clog2(MAX_CYC) : 1;

    typedef enum logic [2:0] {
        S_IDLE    = 3'd0,
        S_ENTRY   = 3'd1,
        S_CHECK   = 3'd2,
        S_OPEN    = 3'd3,
        S_LOCKOUT = 3'd4
    } state_e;

    state_e        state_q, state_d;
    logic [15:0]   entry_q, entry_d;
    logic [2:0]    cnt_q, cnt_d;
    logic [3:0]    disp_q, disp_d;
    logic [1:0]    fail_q, fail_d;
    logic          err_q, err_d;
    logic [TW-1:0] timer_q, timer_d;
    logic          prev_c_q, prev_c_d;
    logic          prev_l_q, prev_l_d;
    logic          prev_u_q, prev_u_d;

    logic press_c, press_l, press_u;

    assign press_c = bus.btnc & ~prev_c_q;
    assign press_l = bus.btnl & ~prev_l_q;
    assign press_u = bus.btnu & ~prev_u_q;

    always_ff @(posedge clk) begin
        if (!reset) begin
            state_q  <= S_IDLE;
            entry_q  <= '0;
            cnt_q    <= '0;
            disp_q   <= '0;
            fail_q   <= '0;
            err_q    <= 1'b0;
            timer_q  <= '0;
            prev_c_q <= 1'b1;
            prev_l_q <= 1'b1;
            prev_u_q <= 1'b1;
        end else begin
            state_q  <= state_d;
            entry_q  <= entry_d;
            cnt_q    <= cnt_d;
            disp_q   <= disp_d;
            fail_q   <= fail_d;
            err_q    <= err_d;
            timer_q  <= timer_d;
            prev_c_q <= prev_c_d;
            prev_l_q <= prev_l_d;
            prev_u_q <= prev_u_d;
        end
    end

    always_comb begin
        state_d  = state_q;
        entry_d  = entry_q;
        cnt_d    = cnt_q;
        disp_d   = disp_q;
        fail_d   = fail_q;
        err_d    = err_q;
        timer_d  = timer_q;
        prev_c_d = bus.btnc;
        prev_l_d = bus.btnl;
        prev_u_d = bus.btnu;
        case (state_q)
            S_IDLE: begin
                if (press_l) begin
                    err_d = 1'b0;
                end else if (press_c) begin
                    entry_d = {entry_q[11:0], bus.swt};
                    cnt_d   = 3'd1;
                    disp_d  = bus.swt;
                    err_d   = 1'b0;
                    state_d = S_ENTRY;
                end
            end
            S_ENTRY: begin
                // Clear beats a simultaneous digit entry.
                if (press_l) begin
                    entry_d = '0;
                    cnt_d   = '0;
                    disp_d  = '0;
                    state_d = S_IDLE;
                end else if (press_c) begin
                    entry_d = {entry_q[11:0], bus.swt};
                    cnt_d   = cnt_q + 3'd1;
                    disp_d  = bus.swt;
                    if (cnt_q == 3'd3) begin
                        state_d = S_CHECK;
                    end
                end
            end
            S_CHECK: begin
                entry_d = '0;
                cnt_d   = '0;
                if (entry_q == CODE) begin
                    fail_d  = '0;
                    timer_d = TW'(OPEN_CYCLES - 1);
                    state_d = S_OPEN;
                end else if (int'(fail_q) + 1 == MAX_FAIL) begin
                    fail_d  = 2'(MAX_FAIL);
                    err_d   = 1'b1;
                    timer_d = TW'(LOCK_CYCLES - 1);
                    state_d = S_LOCKOUT;
                end else begin
                    fail_d  = fail_q + 2'd1;
                    err_d   = 1'b1;
                    state_d = S_IDLE;
                end
            end
            S_OPEN: begin
                if (press_u) begin
                    timer_d = '0;
                    state_d = S_IDLE;
                end else if (timer_q == '0) begin
                    state_d = S_IDLE;
                end else begin
                    timer_d = timer_q - 1'b1;
                end
            end
            S_LOCKOUT: begin
                if (timer_q == '0) begin
                    fail_d  = '0;
                    err_d   = 1'b0;
                    state_d = S_IDLE;
                end else begin
                    timer_d = timer_q - 1'b1;
                end
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase
    end

    always_comb begin
        bus.unlocked   = (state_q == S_OPEN);
        bus.locked_out = (state_q == S_LOCKOUT);
        bus.err        = err_q;
        bus.digit_cnt  = cnt_q;
        bus.disp_digit = disp_q;
        bus.fail_cnt   = fail_q;
    end
endmodule

// File: tb/tb_combo_lock_fsm.sv
// tb/tb_combo_lock_fsm.sv - directed and randomized checks of combo_lock_fsm against a behavioural model
module tb_combo_lock_fsm;
    localparam logic [15:0] CODE = 16'h1234;
    localparam int MAX_FAIL = 3;
    localparam int OPEN_C   = 8;
    localparam int LOCK_C   = 16;

    logic clk = 1'b0;
    logic reset;
    int   checks = 0;
    int   errors = 0;

    combo_lock_fsm_if bus ();

    combo_lock_fsm #(
        .CODE(CODE), .MAX_FAIL(MAX_FAIL), .OPEN_CYCLES(OPEN_C), .LOCK_CYCLES(LOCK_C)
    ) dut (
        .clk(clk), .reset(reset), .bus(bus)
    );

    always #5 clk = ~clk;

    // Reference: pending digits queue plus remaining-cycle counters.
    int       m_q[$];
    int       m_open, m_lock, m_fail;
    bit       m_err, m_check;
    bit [3:0] m_disp;
    bit       m_pc, m_pl, m_pu;

    function automatic void model_step();
        bit pc, pl, pu;
        int code;
        if (!reset) begin
            m_q.delete();
            m_open = 0; m_lock = 0; m_fail = 0;
            m_err = 0; m_check = 0; m_disp = 0;
            m_pc = 1; m_pl = 1; m_pu = 1;
            return;
        end
        pc = bus.btnc && !m_pc;
        pl = bus.btnl && !m_pl;
        pu = bus.btnu && !m_pu;
        m_pc = bus.btnc; m_pl = bus.btnl; m_pu = bus.btnu;
        if (m_lock > 0) begin
            m_lock--;
            if (m_lock == 0) begin m_fail = 0; m_err = 0; end
        end else if (m_open > 0) begin
            if (pu) m_open = 0;
            else    m_open--;
        end else if (m_check) begin
            code = 0;
            foreach (m_q[i]) code = code * 16 + m_q[i];
            m_q.delete();
            m_check = 0;
            if (code == int'(CODE)) begin
                m_fail = 0;
                m_open = OPEN_C;
            end else begin
                m_fail++;
                m_err = 1;
                if (m_fail == MAX_FAIL) m_lock = LOCK_C;
            end
        end else if (pl) begin
            m_err = 0;
            if (m_q.size() > 0) m_disp = 0;
            m_q.delete();
        end else if (pc) begin
            m_q.push_back(int'(bus.swt));
            m_disp = bus.swt;
            m_err = 0;
            if (m_q.size() == 4) m_check = 1;
        end
    endfunction

    task automatic check(input string tag, input logic [15:0] obs, input logic [15:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
        end
    endtask

    task automatic compare_all();
        check("unlocked",   16'(bus.unlocked),   16'(m_open > 0));
        check("locked_out", 16'(bus.locked_out), 16'(m_lock > 0));
        check("err",        16'(bus.err),        16'(m_err));
        check("digit_cnt",  16'(bus.digit_cnt),  16'(m_q.size()));
        check("disp_digit", 16'(bus.disp_digit), 16'(m_disp));
        check("fail_cnt",   16'(bus.fail_cnt),   16'(m_fail));
    endtask

    task automatic tick();
        @(posedge clk);
        model_step();
        #1;
        compare_all();
    endtask

    task automatic press_c(input logic [3:0] d);
        bus.swt = d; bus.btnc = 1'b1; tick();
        bus.btnc = 1'b0; tick();
    endtask

    task automatic press_l();
        bus.btnl = 1'b1; tick();
        bus.btnl = 1'b0; tick();
    endtask

    task automatic enter_code(input logic [15:0] c);
        for (int i = 3; i >= 0; i--) press_c(c[i*4 +: 4]);
    endtask

    task automatic do_reset();
        reset = 1'b0; tick();
        reset = 1'b1;
    endtask

    initial begin
        int n;
        int op;
        int k;
        logic [15:0] code_v;
        code_v = CODE;
        reset = 1'b0;
        bus.btnc = 1'b0; bus.btnl = 1'b0; bus.btnu = 1'b0; bus.swt = 4'd0;
        tick();
        check("reset_unlocked", 16'(bus.unlocked), 16'd0);
        check("reset_digit_cnt", 16'(bus.digit_cnt), 16'd0);
        tick();
        reset = 1'b1;
        tick();

        // Correct code: open two edges after 4th press, for OPEN_C cycles
        enter_code(16'h1234);
        check("open_latency", 16'(bus.unlocked), 16'd1);
        n = 1;
        for (int i = 0; i < 30 && bus.unlocked; i++) begin
            tick();
            if (bus.unlocked) n++;
        end
        check("open_cycles", 16'(n), 16'(OPEN_C));
        check("open_fail_cnt", 16'(bus.fail_cnt), 16'd0);

        // Wrong code then recovery
        enter_code(16'h1235);
        check("wrong_err", 16'(bus.err), 16'd1);
        check("wrong_fail", 16'(bus.fail_cnt), 16'd1);
        check("wrong_unlocked", 16'(bus.unlocked), 16'd0);
        press_c(4'd9);
        check("recover_err", 16'(bus.err), 16'd0);
        check("recover_cnt", 16'(bus.digit_cnt), 16'd1);
        press_l();

        // Lockout after three consecutive mismatches; presses ignored
        do_reset();
        tick();
        enter_code(16'h4321);
        enter_code(16'h0000);
        enter_code(16'hFFFF);
        check("lockout_entry", 16'(bus.locked_out), 16'd1);
        n = 1;
        for (int i = 0; i < 40 && bus.locked_out; i++) begin
            bus.btnc = i[0]; bus.btnl = i[1]; bus.swt = 4'(i);
            tick();
            check("lockout_no_digit", 16'(bus.digit_cnt), 16'd0);
            if (bus.locked_out) n++;
        end
        bus.btnc = 1'b0; bus.btnl = 1'b0;
        check("lockout_cycles", 16'(n), 16'(LOCK_C));
        check("lockout_fail_clr", 16'(bus.fail_cnt), 16'd0);
        tick();

        // Clear and collision
        press_c(4'd1);
        press_c(4'd2);
        press_l();
        check("clear_cnt", 16'(bus.digit_cnt), 16'd0);
        check("clear_disp", 16'(bus.disp_digit), 16'd0);
        bus.swt = 4'd3; bus.btnc = 1'b1; bus.btnl = 1'b1; tick();
        bus.btnc = 1'b0; bus.btnl = 1'b0; tick();
        check("collide_cnt", 16'(bus.digit_cnt), 16'd0);

        // Held button gives one press; held through reset gives none
        bus.swt = 4'd7; bus.btnc = 1'b1;
        repeat (10) tick();
        bus.btnc = 1'b0; tick();
        check("held_cnt", 16'(bus.digit_cnt), 16'd1);
        check("held_disp", 16'(bus.disp_digit), 16'd7);
        press_l();
        bus.btnc = 1'b1;
        do_reset();
        repeat (3) tick();
        bus.btnc = 1'b0; tick();
        check("held_reset_cnt", 16'(bus.digit_cnt), 16'd0);

        // Early relock with btnu
        enter_code(16'h1234);
        tick(); tick();
        bus.btnu = 1'b1; tick();
        check("relock", 16'(bus.unlocked), 16'd0);
        bus.btnu = 1'b0; tick();

        // Reset during lockout
        enter_code(16'h1111);
        enter_code(16'h2222);
        enter_code(16'h3333);
        repeat (5) tick();
        check("pre_reset_lock", 16'(bus.locked_out), 16'd1);
        do_reset();
        check("reset_lock", 16'(bus.locked_out), 16'd0);
        check("reset_err", 16'(bus.err), 16'd0);
        check("reset_fail", 16'(bus.fail_cnt), 16'd0);
        tick();

        // Randomized traffic, biased toward the correct digits
        for (int it = 0; it < 300; it++) begin
            op = $urandom_range(0, 11);
            if ($urandom_range(0, 99) == 0) begin
                do_reset();
            end else if (op <= 5) begin
                k = m_q.size();
                if (k < 4 && $urandom_range(0, 2) != 0) bus.swt = code_v[15 - 4*k -: 4];
                else bus.swt = 4'($urandom_range(0, 15));
                bus.btnc = 1'b1;
                repeat ($urandom_range(1, 3)) tick();
                bus.btnc = 1'b0;
                repeat ($urandom_range(1, 3)) tick();
            end else if (op == 6) begin
                bus.btnl = 1'b1; bus.btnc = 1'($urandom_range(0, 1));
                tick();
                bus.btnl = 1'b0; bus.btnc = 1'b0;
                tick();
            end else if (op == 7) begin
                bus.btnu = 1'b1; tick();
                bus.btnu = 1'b0; tick();
            end else begin
                repeat ($urandom_range(1, 5)) tick();
            end
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
